// File: rtl/tff_counter_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tff_ctrl_pkg
// Description : Shared types and constants for the T-cell counter sequencer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package tff_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Count direction encoding, as seen on the dir input
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : tff_ctrl_pkg
`default_nettype wire

// File: rtl/tff_counter_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tff_counter_ctrl_if
// Description : Command / status bundle between a command source and the
//               T-cell counter sequencer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] target;
    logic             hold;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic             busy;
    logic             done;

    // Command source side
    modport master (
        output start, dir, target, hold, clr,
        input  count, count_n, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, dir, target, hold, clr,
        output count, count_n, busy, done
    );
endinterface : tff_counter_ctrl_if
`default_nettype wire

// File: rtl/tff_counter_ctrl_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tff_cell
// Description : Single toggle flip-flop with true and complement outputs,
//               both held in their own flops.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tff_cell (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic t,
    output logic      q,
    output logic      qbar
);
    logic q_q, q_d;
    logic qbar_q, qbar_d;

    // Next value: invert both rails when enabled, otherwise keep them
    always_comb begin
        q_d    = q_q;
        qbar_d = qbar_q;
        if (t) begin
            q_d    = ~q_q;
            qbar_d = ~qbar_q;
        end
    end

    // Cell storage; qbar has its own flop so it never lags q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= 1'b0;
            qbar_q <= 1'b1;
        end else begin
            q_q    <= q_d;
            qbar_q <= qbar_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;
endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tff_counter_ctrl
// Description : Sequences a bank of T cells as an up/down counter that runs
//               to a latched target, with clear/abort and hold.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    tff_counter_ctrl_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             dir_q, dir_d;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;

    // Carry chains: a bit toggles when every lower bit is 1 (up) or 0 (down)
    always_comb begin : p_chain
        logic up_c;
        logic dn_c;
        up_c   = 1'b1;
        dn_c   = 1'b1;
        w_up_t = '0;
        w_dn_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_t[i] = up_c;
            w_dn_t[i] = dn_c;
            up_c      = up_c & w_q[i];
            dn_c      = dn_c & w_qbar[i];
        end
    end

    // Next-state and toggle-enable decode; clear toggles only the set bits
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        w_t      = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr) begin
                    w_t = w_q;
                end else if (bus.start) begin
                    target_d = bus.target;
                    dir_d    = bus.dir;
                    state_d  = (bus.target == w_q) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clr) begin
                    w_t     = w_q;
                    state_d = ST_IDLE;
                end else if (w_q == target_q) begin
                    state_d = ST_DONE;
                end else if (!bus.hold) begin
                    w_t = (dir_q == DIR_UP) ? w_up_t : w_dn_t;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            dir_q    <= DIR_UP;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dir_q    <= dir_d;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
            tff_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .t    (w_t[gi]),
                .q    (w_q[gi]),
                .qbar (w_qbar[gi])
            );
        end
    endgenerate

    assign bus.count   = w_q;
    assign bus.count_n = w_qbar;
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
endmodule : tff_counter_ctrl
`default_nettype wire
